// File: rtl/spi_cmd_regfile.sv
// spi_cmd_regfile
// Command decoder and double-buffered configuration register bank fed by
// decoded 16-bit SPI packets {addr, data}. Writes land in a shadow bank and
// are copied to the active bank only by a keyed commit command. Readback,
// commit acknowledge and error responses are queued in a small show-ahead
// FIFO that is drained over a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_packet_valid     one-cycle strobe, i_packet_data holds a packet
//   i_packet_data      [15:8] address byte, [7:0] data byte
//   o_cfg              active bank, register k at [8k+7:8k]
//   o_commit_pulse     one-cycle pulse when the active bank is updated
//   o_resp_valid       response FIFO not empty
//   o_resp_data        FIFO head word (0 when empty)
//   i_resp_ready       consumer takes the head when valid & ready
//   o_err_count        saturating count of rejected packets
//   o_resp_overflow    sticky flag, a response was dropped on a full FIFO

module spi_cmd_regfile #(
   parameter int         N_REGS      = 16,
   parameter int         FIFO_DEPTH  = 4,
   parameter logic [7:0] ADDR_COMMIT = 8'h80,
   parameter logic [7:0] ADDR_READ   = 8'h81,
   parameter logic [7:0] COMMIT_KEY  = 8'hA5
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_packet_valid,
   input  logic [15:0]           i_packet_data,
   output logic [8*N_REGS-1:0]   o_cfg,
   output logic                  o_commit_pulse,
   output logic                  o_resp_valid,
   output logic [15:0]           o_resp_data,
   input  logic                  i_resp_ready,
   output logic [7:0]            o_err_count,
   output logic                  o_resp_overflow
);

   localparam int             IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam int             PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [8:0]     N_REGS_C = 9'(N_REGS);
   localparam logic [PTR_W:0] DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W:0] ONE_C    = (PTR_W+1)'(1);

   logic [7:0]  shadow [N_REGS];
   logic [7:0]  active [N_REGS];

   logic        pkt_valid_q;
   logic [15:0] pkt_q;
   logic [7:0]  addr;
   logic [7:0]  data;

   logic        do_write;
   logic        do_commit;
   logic        is_err;
   logic        push;
   logic [15:0] push_word;

   logic [15:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count_q;
   logic           full;
   logic           pop;
   logic           push_ok;

   // Packets are registered first and decoded one cycle later, giving the
   // fixed one-cycle latency. Reset clears the stage so a packet presented
   // together with reset is discarded.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pkt_valid_q <= 1'b0;
         pkt_q       <= '0;
      end else begin
         pkt_valid_q <= i_packet_valid;
         pkt_q       <= i_packet_data;
      end
   end

   assign addr = pkt_q[15:8];
   assign data = pkt_q[7:0];

   // Command decode. Register writes produce no response; every other
   // outcome (commit ack, readback, error) pushes exactly one word.
   always_comb begin
      do_write  = 1'b0;
      do_commit = 1'b0;
      is_err    = 1'b0;
      push      = 1'b0;
      push_word = '0;
      if (pkt_valid_q) begin
         if ({1'b0, addr} < N_REGS_C) begin
            do_write = 1'b1;
         end else if (addr == ADDR_COMMIT && data == COMMIT_KEY) begin
            do_commit = 1'b1;
            push      = 1'b1;
            push_word = {8'hC0, COMMIT_KEY};
         end else if (addr == ADDR_READ && {1'b0, data} < N_REGS_C) begin
            push      = 1'b1;
            push_word = {data, active[data[IDX_W-1:0]]};
         end else begin
            is_err    = 1'b1;
            push      = 1'b1;
            push_word = {8'hEE, addr};
         end
      end
   end

   // Shadow and active banks. A commit copies the whole shadow bank in one
   // edge so the outputs never show a partially updated configuration.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < N_REGS; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
         o_commit_pulse <= 1'b0;
      end else begin
         if (do_write) begin
            shadow[addr[IDX_W-1:0]] <= data;
         end
         if (do_commit) begin
            for (int k = 0; k < N_REGS; k++) begin
               active[k] <= shadow[k];
            end
         end
         o_commit_pulse <= do_commit;
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_REGS; g++) begin : g_cfg
         assign o_cfg[8*g +: 8] = active[g];
      end
   endgenerate

   // Error counter saturates at 0xFF; overflow is sticky until reset. Both
   // update even when the error response itself is dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_err_count     <= '0;
         o_resp_overflow <= 1'b0;
      end else begin
         if (is_err && o_err_count != 8'hFF) begin
            o_err_count <= o_err_count + 8'd1;
         end
         if (push && !push_ok) begin
            o_resp_overflow <= 1'b1;
         end
      end
   end

   // A full FIFO can still accept a push when the head leaves the same cycle.
   assign full    = (count_q == DEPTH_C);
   assign pop     = o_resp_valid & i_resp_ready;
   assign push_ok = push & (!full | pop);

   // Response FIFO pointers and occupancy; pointers wrap naturally since the
   // depth is a power of two.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + ONE_C;
            2'b01:   count_q <= count_q - ONE_C;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible once written.
   always_ff @(posedge i_clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_word;
      end
   end

   assign o_resp_valid = (count_q != '0);
   assign o_resp_data  = o_resp_valid ? mem[rd_ptr] : 16'h0000;

endmodule

// File: doc/spi_cmd_regfile.md
Name: spi_cmd_regfile

Overview:
- Consumes decoded 16-bit SPI packets {addr, data} from the SPI slave packet stage.
- Maintains a double-buffered configuration register bank: shadow writes, then atomic commit to active outputs.
- Generates 16-bit response words (readback, commit ack, error) into a small FIFO drained by the UART transmit path over a valid/ready handshake.

Parameters:
- N_REGS, 16, number of 8-bit config registers (2..128); register index = addr[6:0].
- FIFO_DEPTH, 4, response FIFO entries (power of two, >=2).
- ADDR_COMMIT, 8'h80, command address: commit shadow to active.
- ADDR_READ, 8'h81, command address: readback; data byte = register index.
- COMMIT_KEY, 8'hA5, data byte required for a valid commit.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset
- i_packet_valid  in  1  one-cycle strobe, packet present
- i_packet_data  in  16  [15:8] address byte, [7:0] data byte
- o_cfg  out  8*N_REGS  active registers, reg k at [8k+7:8k]
- o_commit_pulse  out  1  one-cycle pulse when active bank updated
- o_resp_valid  out  1  response FIFO not empty
- o_resp_data  out  16  FIFO head word (show-ahead)
- i_resp_ready  in  1  consumer accepts head when valid&ready
- o_err_count  out  8  saturating count of rejected packets
- o_resp_overflow  out  1  sticky: a response was dropped on full FIFO

Behaviour:
- Reset is i_rst, synchronous, active-high; clock is i_clk. On reset: shadow and active banks = 0, o_commit_pulse = 0, FIFO empty (o_resp_valid = 0, o_resp_data = 0), o_err_count = 0, o_resp_overflow = 0. Reset mid-transaction discards the packet and any pending response.
- Decode happens only when i_packet_valid = 1. Packet sampled at edge T; all effects are visible after edge T+1, i.e. 1-cycle latency.
- Addr < N_REGS: shadow[addr] <= data. No response. o_cfg unchanged.
- Addr == ADDR_COMMIT and data == COMMIT_KEY:
  - Active bank <= shadow bank (all registers at once).
  - o_commit_pulse = 1 for exactly one cycle.
  - Push response {8'hC0, COMMIT_KEY}.
- Addr == ADDR_COMMIT and data != COMMIT_KEY: error.
- Addr == ADDR_READ and data < N_REGS: push {data, active[data]}. Readback returns the active value, never the shadow value.
- Addr == ADDR_READ and data >= N_REGS: error.
- Any other address: error.
- Error handling:
  - Push {8'hEE, addr}.
  - o_err_count += 1, saturating at 8'hFF; it never wraps.
  - No register changes.
- FIFO:
  - Pop occurs when o_resp_valid & i_resp_ready.
  - A push is accepted when count < FIFO_DEPTH, or when full with a pop in the same cycle.
  - A push into an empty FIFO makes o_resp_valid = 1 with o_resp_data = the pushed word on the next cycle.
  - Order is strictly FIFO. Read and write pointers wrap modulo FIFO_DEPTH.
- Overflow: a push while full with no pop is dropped, sets o_resp_overflow (cleared only by reset). Register side effects of that packet (commit, error count) still occur.
- o_resp_data holds its value while !i_resp_ready. It must not change while o_resp_valid = 1 and no pop occurs.
- i_packet_valid on consecutive cycles is supported: one packet per cycle, no backpressure to the upstream stage.

Test Plan:
- Reset, then write packets 0x0312, 0x0734 -> o_cfg unchanged (all 0). Send 0x80A5 -> next cycle o_cfg reg3 = 0x12, reg7 = 0x34, o_commit_pulse high exactly 1 cycle, response 0xC0A5.
- Write 0x0255 without commit, then 0x8102 -> response 0x0200 (active, not shadow). After 0x80A5 then 0x8102 -> responses 0xC0A5, 0x0255 in order.
- Bad packets 0x8000, 0x8110, 0x4012 -> responses 0xEE80, 0xEE81, 0xEE40; o_err_count = 3; o_cfg unchanged. Send 300 bad packets -> o_err_count = 0xFF.
- i_resp_ready = 0, send 5 readbacks of reg1 (depth 4) -> 4 valid entries, o_resp_overflow = 1. With FIFO full, assert ready and push in the same cycle -> push accepted, count stays 4.
- Back-to-back packets on consecutive cycles with random i_resp_ready -> responses delivered in order, none lost when no overflow, o_resp_data stable while stalled.
- Assert i_rst with 3 FIFO entries and committed registers -> next cycle o_resp_valid = 0, o_cfg = 0, o_err_count = 0, overflow cleared; a packet sampled together with reset has no effect.
